// File: rtl/phase_timer.sv
// Phase duration timer for the washing-machine controller: counts the active
// phase down in prescaled time units and pulses Tempo when it expires.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | no legal phase (all-zero or illegal vector), counters cleared
// S_RUN   | run phase active, prescaler counting, restante decrementing
// S_PAUSE | pausar held, prescaler and restante frozen
// S_DONE  | phase expired, restante held at 0, waiting for a phase change
module phase_timer #(
  parameter int unsigned PRESCALE      = 1000,
  parameter logic [7:0]  T_MOLHO       = 8'd10,
  parameter logic [7:0]  T_LAVAR       = 8'd20,
  parameter logic [7:0]  T_ENXAGUE     = 8'd15,
  parameter logic [7:0]  T_CENTRIFUGAR = 8'd12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       molho,
  input  logic       lavar,
  input  logic       enxague,
  input  logic       centrifugar,
  input  logic       pausar,
  output logic       Tempo,
  output logic [7:0] restante,
  output logic       erro
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [15:0] PS_LAST     = 16'(PRESCALE - 1);
  localparam logic [4:0]  PH_PAUSAR   = 5'b10000;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [4:0]  r_prev_phase;
  logic [15:0] r_presc;
  logic [15:0] w_presc_nxt;
  logic [7:0]  r_restante;
  logic [7:0]  w_restante_nxt;
  logic        r_tempo;
  logic        w_tempo_nxt;
  logic        r_erro;

  logic [4:0]  w_phase;
  logic        w_multi;
  logic        w_zero;
  logic        w_change;
  logic        w_pause_phase;
  logic        w_prev_pause;
  logic        w_wrap;
  logic [7:0]  w_load_val;

  // A zero duration would never expire through the 1->0 path, so load 1.
  function automatic logic [7:0] f_nonzero(input logic [7:0] t);
    return (t == 8'd0) ? 8'd1 : t;
  endfunction

  assign w_phase       = {pausar, centrifugar, enxague, lavar, molho};
  assign w_multi       = (w_phase & (w_phase - 5'd1)) != 5'd0;
  assign w_zero        = (w_phase == 5'd0) || w_multi;
  assign w_change      = w_phase != r_prev_phase;
  assign w_pause_phase = w_phase == PH_PAUSAR;
  assign w_prev_pause  = r_prev_phase == PH_PAUSAR;
  assign w_wrap        = r_presc == PS_LAST;

  always_comb begin
    w_load_val = 8'd1;
    if (molho)            w_load_val = f_nonzero(T_MOLHO);
    else if (lavar)       w_load_val = f_nonzero(T_LAVAR);
    else if (enxague)     w_load_val = f_nonzero(T_ENXAGUE);
    else if (centrifugar) w_load_val = f_nonzero(T_CENTRIFUGAR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_prev_phase <= 5'd0;
      r_presc      <= 16'd0;
      r_restante   <= 8'd0;
      r_tempo      <= 1'b0;
      r_erro       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_prev_phase <= w_phase;
      r_presc      <= w_presc_nxt;
      r_restante   <= w_restante_nxt;
      r_tempo      <= w_tempo_nxt;
      r_erro       <= w_multi;
    end
  end

  // A phase change always takes priority over a prescaler wrap.
  always_comb begin
    w_state_nxt    = r_state;
    w_presc_nxt    = r_presc;
    w_restante_nxt = r_restante;
    w_tempo_nxt    = 1'b0;
    if (w_zero) begin
      w_state_nxt    = S_IDLE;
      w_presc_nxt    = 16'd0;
      w_restante_nxt = 8'd0;
    end else if (w_change) begin
      if (w_pause_phase) begin
        if (r_state == S_RUN || r_state == S_DONE) begin
          w_state_nxt = S_PAUSE;
        end
      end else if (w_prev_pause && r_state == S_PAUSE && centrifugar) begin
        w_state_nxt = (r_restante != 8'd0) ? S_RUN : S_DONE;
      end else begin
        w_state_nxt    = S_RUN;
        w_presc_nxt    = 16'd0;
        w_restante_nxt = w_load_val;
      end
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_wrap) begin
            w_presc_nxt    = 16'd0;
            w_restante_nxt = r_restante - 8'd1;
            if (r_restante == 8'd1) begin
              w_state_nxt = S_DONE;
              w_tempo_nxt = 1'b1;
            end
          end else begin
            w_presc_nxt = r_presc + 16'd1;
          end
        end
        default: begin
          w_state_nxt = r_state;
        end
      endcase
    end
  end

  assign Tempo    = r_tempo;
  assign restante = r_restante;
  assign erro     = r_erro;

endmodule

// File: tb/tb_phase_timer.sv
// Scoreboard bench for phase_timer: stimulus queues expected snapshots and
// Tempo pulse cycles; independent monitors pop and compare them.
module tb_phase_timer;

  logic       clk = 1'b0;
  logic       reset;
  logic       molho, lavar, enxague, centrifugar, pausar;
  logic       Tempo, erro;
  logic [7:0] restante;

  int         cyc = 0;
  int         total = 0;
  int         bad = 0;

  int         q_cyc[$];
  logic [9:0] q_val[$];
  string      q_name[$];
  int         pulse_q[$];
  logic       chk_tgl = 1'b0;
  logic       prev_tempo = 1'b0;

  int         m_c;
  logic [9:0] m_v;
  string      m_n;
  int         p_c;

  phase_timer #(
    .PRESCALE      (4),
    .T_MOLHO       (8'd3),
    .T_LAVAR       (8'd2),
    .T_ENXAGUE     (8'd15),
    .T_CENTRIFUGAR (8'd5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .molho       (molho),
    .lavar       (lavar),
    .enxague     (enxague),
    .centrifugar (centrifugar),
    .pausar      (pausar),
    .Tempo       (Tempo),
    .restante    (restante),
    .erro        (erro)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic set_ph(input logic [4:0] v);
    {pausar, centrifugar, enxague, lavar, molho} = v;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic expect_at(input int c, input string n, input logic t,
                           input logic [7:0] r, input logic e);
    q_cyc.push_back(c);
    q_val.push_back({t, r, e});
    q_name.push_back(n);
  endtask

  // Snapshot monitor: compares every queued expectation due at this cycle.
  initial forever begin
    @(negedge clk or chk_tgl);
    while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
      m_c = q_cyc.pop_front();
      m_v = q_val.pop_front();
      m_n = q_name.pop_front();
      total++;
      if (m_c != cyc) begin
        bad++;
        $display("FAIL %s missed: due cyc=%0d seen at cyc=%0d", m_n, m_c, cyc);
      end else if ({Tempo, restante, erro} !== m_v) begin
        bad++;
        $display("FAIL %s cyc=%0d got tempo=%0b restante=%0d erro=%0b expected tempo=%0b restante=%0d erro=%0b",
                 m_n, cyc, Tempo, restante, erro, m_v[9], m_v[8:1], m_v[0]);
      end
    end
  end

  // Pulse monitor: every Tempo pulse must match the next expected pulse cycle.
  initial forever begin
    @(negedge clk);
    if (Tempo === 1'b1) begin
      total++;
      if (prev_tempo === 1'b1) begin
        bad++;
        $display("FAIL tempo_consecutive cyc=%0d got two high cycles expected single pulse", cyc);
      end else if (pulse_q.size() == 0) begin
        bad++;
        $display("FAIL tempo_unexpected cyc=%0d got pulse expected none", cyc);
      end else begin
        p_c = pulse_q.pop_front();
        if (p_c != cyc) begin
          bad++;
          $display("FAIL tempo_cycle got pulse at cyc=%0d expected cyc=%0d", cyc, p_c);
        end
      end
    end
    prev_tempo = Tempo;
  end

  initial begin
    #20000;
    $display("FAIL timeout cyc=%0d got no completion expected finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    set_ph(5'b00000);
    wait_cyc(2);

    // reset held with molho present, then released between edges
    expect_at(3, "reset_state", 1'b0, 8'd0, 1'b0);
    set_ph(5'b00001);
    wait_cyc(1);
    reset = 1'b0;
    expect_at(4,  "molho_load",  1'b0, 8'd3, 1'b0);
    expect_at(7,  "molho_hold",  1'b0, 8'd3, 1'b0);
    expect_at(8,  "molho_dec1",  1'b0, 8'd2, 1'b0);
    expect_at(12, "molho_dec2",  1'b0, 8'd1, 1'b0);
    expect_at(15, "molho_pre0",  1'b0, 8'd1, 1'b0);
    expect_at(16, "molho_exp",   1'b1, 8'd0, 1'b0);
    expect_at(17, "molho_done",  1'b0, 8'd0, 1'b0);
    pulse_q.push_back(16);
    wait_cyc(17);

    // next phase after expiry
    set_ph(5'b00010);
    expect_at(21, "lavar_load",  1'b0, 8'd2, 1'b0);
    expect_at(25, "lavar_dec",   1'b0, 8'd1, 1'b0);
    expect_at(29, "lavar_exp",   1'b1, 8'd0, 1'b0);
    expect_at(30, "lavar_done",  1'b0, 8'd0, 1'b0);
    pulse_q.push_back(29);
    wait_cyc(11);

    // illegal vector, then back to legal
    set_ph(5'b00110);
    expect_at(32, "illegal_erro", 1'b0, 8'd0, 1'b1);
    expect_at(34, "illegal_hold", 1'b0, 8'd0, 1'b1);
    wait_cyc(3);
    set_ph(5'b00010);
    expect_at(35, "legal_reload", 1'b0, 8'd2, 1'b0);
    expect_at(43, "legal_exp",    1'b1, 8'd0, 1'b0);
    pulse_q.push_back(43);
    wait_cyc(10);

    // phase change on the same edge as a prescaler wrap
    set_ph(5'b00000);
    expect_at(45, "zero_idle", 1'b0, 8'd0, 1'b0);
    wait_cyc(1);
    set_ph(5'b00010);
    expect_at(46, "coll_load", 1'b0, 8'd2, 1'b0);
    wait_cyc(4);
    set_ph(5'b00100);
    expect_at(50, "collision",  1'b0, 8'd15, 1'b0);
    expect_at(53, "coll_hold",  1'b0, 8'd15, 1'b0);
    expect_at(54, "coll_dec",   1'b0, 8'd14, 1'b0);
    wait_cyc(6);

    // abandoning a phase on its expiry edge suppresses the pulse
    set_ph(5'b00001);
    expect_at(56, "aband_load", 1'b0, 8'd3, 1'b0);
    expect_at(67, "aband_last", 1'b0, 8'd1, 1'b0);
    wait_cyc(12);
    set_ph(5'b00010);
    expect_at(68, "aband_reload", 1'b0, 8'd2, 1'b0);
    expect_at(76, "aband_exp",    1'b1, 8'd0, 1'b0);
    pulse_q.push_back(76);
    wait_cyc(10);

    // pause and resume
    set_ph(5'b01000);
    expect_at(78, "centr_load", 1'b0, 8'd5, 1'b0);
    expect_at(86, "centr_at3",  1'b0, 8'd3, 1'b0);
    wait_cyc(10);
    set_ph(5'b10000);
    expect_at(88,  "pause_enter", 1'b0, 8'd3, 1'b0);
    expect_at(100, "pause_mid",   1'b0, 8'd3, 1'b0);
    expect_at(107, "pause_end",   1'b0, 8'd3, 1'b0);
    wait_cyc(20);
    set_ph(5'b01000);
    expect_at(108, "resume",      1'b0, 8'd3, 1'b0);
    expect_at(110, "resume_hold", 1'b0, 8'd3, 1'b0);
    expect_at(111, "resume_dec",  1'b0, 8'd2, 1'b0);
    expect_at(119, "resume_exp",  1'b1, 8'd0, 1'b0);
    expect_at(120, "resume_done", 1'b0, 8'd0, 1'b0);
    pulse_q.push_back(119);
    wait_cyc(14);

    // asynchronous reset pulse between edges while running at restante=4
    set_ph(5'b00000);
    wait_cyc(1);
    set_ph(5'b01000);
    expect_at(123, "pre_rst_load", 1'b0, 8'd5, 1'b0);
    expect_at(127, "pre_rst_at4",  1'b0, 8'd4, 1'b0);
    wait_cyc(6);
    reset = 1'b1;
    #1;
    expect_at(128, "async_reset", 1'b0, 8'd0, 1'b0);
    chk_tgl = ~chk_tgl;
    #1;
    reset = 1'b0;
    expect_at(129, "post_rst_load", 1'b0, 8'd5, 1'b0);
    expect_at(133, "post_rst_dec",  1'b0, 8'd4, 1'b0);
    expect_at(149, "post_rst_exp",  1'b1, 8'd0, 1'b0);
    pulse_q.push_back(149);
    wait_cyc(22);
    wait_cyc(3);

    while (q_cyc.size() > 0) begin
      total++;
      bad++;
      $display("FAIL %s got no check expected check at cyc=%0d", q_name.pop_front(), q_cyc.pop_front());
      void'(q_val.pop_front());
    end
    while (pulse_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL tempo_missing got no pulse expected pulse at cyc=%0d", pulse_q.pop_front());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
